bcd_serial_sub: RTL and testbench
=================================

BCD_SERIAL_SUB -- requirements
Module: bcd_serial_sub

Interface
REQ-001 Parameter: NDIG, default 4, number of BCD digits per operand (1..8).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: start  input  1  request; sampled only in IDLE.
REQ-005 Port: a  input  4*NDIG  minuend, packed BCD, digit 0 = bits [3:0].
REQ-006 Port: b  input  4*NDIG  subtrahend, packed BCD.
REQ-007 Port: busy  output  1  high in every state except IDLE.
REQ-008 Port: done  output  1  one-cycle pulse; result valid.
REQ-009 Port: diff  output  4*NDIG  magnitude |a-b|, packed BCD.
REQ-010 Port: neg  output  1  high when a<b.
REQ-011 Port: err  output  1  high when any latched input digit >9.

Function
REQ-012 The block SHALL be a registered FSM with states IDLE, SUB, NEG, DONE, and SHALL process one digit per cycle through a digit index register.
REQ-013 In IDLE with start=1, the block SHALL latch a and b, set index=0 and borrow=0, clear diff, neg and err, then go to SUB. If any digit of a or b >9, it SHALL instead set err=1, keep diff=0 and neg=0, and go straight to DONE.
REQ-014 In SUB, per cycle: t = a_i - b_i - borrow; if t<0, then diff_i=t+10 and borrow=1, else diff_i=t and borrow=0; then index+1.
REQ-015 After digit NDIG-1 in SUB: if the final borrow is 1, the block SHALL set neg=1, reset index and borrow to 0, and go to NEG; otherwise it SHALL go to DONE.
REQ-016 In NEG, per cycle: t = 0 - diff_i - borrow, with the same rule as REQ-014 (ten's complement of the result); after digit NDIG-1 it SHALL go to DONE.
REQ-017 DONE SHALL last exactly one cycle with done=1; the next state SHALL be IDLE.
REQ-018 Latency, with start sampled at cycle 0:
- done high in cycle NDIG+1 when a>=b;
- done high in cycle 2*NDIG+1 when a<b;
- done high in cycle 1 on err.
REQ-019 While busy=1, start SHALL be ignored; start during the DONE cycle SHALL also be ignored.
REQ-020 diff, neg and err SHALL hold their values from DONE until the next accepted start.
REQ-021 Internal digit arithmetic SHALL use 5-bit signed (or 4-bit plus borrow) width; diff digits SHALL always be in 0..9.
REQ-022 a=b SHALL give diff=0 and neg=0 (no negative zero).

Reset
REQ-023 With rst=1 at a clock edge, the block SHALL go to IDLE and clear busy, done, diff, neg, err, index, borrow and the operand registers.
REQ-024 rst SHALL take priority over start on the same edge.
REQ-025 rst in SUB, NEG or DONE SHALL abort the operation; done SHALL not pulse for the aborted operation.

Structure
REQ-026 The shared package bcd_pkg SHALL hold:
- state encoding (IDLE, SUB, NEG, DONE);
- BCD_MAX=9;
- BCD_BASE=10;
- digit width 4.
REQ-027 Single-digit borrow logic SHALL be one combinational sub-module, bcd_digit_sub (ports: x, y, bin -> d, bout), instantiated once and shared by SUB and NEG through input muxing.

Verification (NDIG=4)
REQ-028 a=0x5432, b=0x1234 -> diff=0x4198, neg=0, err=0; done in cycle 5.
REQ-029 a=0x1234, b=0x5432 -> diff=0x4198, neg=1; done in cycle 9; busy high cycles 1-9.
REQ-030 a=0x1000, b=0x0001 -> diff=0x0999, neg=0 (borrow ripples through three digits).
REQ-031 a=0x12A4, b=0x0001 -> err=1, diff=0x0000, neg=0; done in cycle 1.
REQ-032 a=b=0x9999 -> diff=0x0000, neg=0; then start pulsed at cycles 2-4 -> ignored, only one done.
REQ-033 start (a=0x1234, b=0x5432), rst=1 in cycle 3 -> busy=0 and outputs zero from cycle 4, no done; a new start afterwards completes normally.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD subtractor: FSM encoding, BCD limits
// and the digit-validity helper.
package bcd_pkg;

  localparam int DIGIT_W  = 4;
  localparam int BCD_MAX  = 9;
  localparam int BCD_BASE = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic digit_invalid(input logic [DIGIT_W-1:0] dig);
    return dig > DIGIT_W'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// One BCD digit of x - y - bin with decimal borrow; purely combinational and
// shared between the subtract and ten's-complement passes.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  input  logic               bin,
  output logic [DIGIT_W-1:0] d,
  output logic               bout
);

  localparam logic [DIGIT_W:0] BASE = (DIGIT_W+1)'(BCD_BASE);

  logic [DIGIT_W:0] t;
  logic [DIGIT_W:0] t_fix;

  // Operand range keeps t within -10..9, so the top bit of the 5-bit
  // two's-complement difference is exactly the outgoing borrow.
  always_comb begin
    t     = {1'b0, x} - {1'b0, y} - {{DIGIT_W{1'b0}}, bin};
    bout  = t[DIGIT_W];
    t_fix = bout ? (t + BASE) : t;
    d     = t_fix[DIGIT_W-1:0];
  end

endmodule

// File: rtl/bcd_serial_sub.sv
// Digit-serial BCD subtractor returning |a-b| with a sign flag; a negative
// raw result is converted to magnitude by a second ten's-complement pass.
module bcd_serial_sub
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DIGIT_W*NDIG-1:0] a,
  input  logic [DIGIT_W*NDIG-1:0] b,
  output logic                    busy,
  output logic                    done,
  output logic [DIGIT_W*NDIG-1:0] diff,
  output logic                    neg,
  output logic                    err
);

  localparam int W  = DIGIT_W * NDIG;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   diff_q, diff_d;
  logic           neg_q, neg_d;
  logic           err_q, err_d;
  logic           borrow_q, borrow_d;
  logic [IW-1:0]  idx_q, idx_d;

  logic [NDIG-1:0]    digit_bad;
  logic               in_bad;
  logic               last_digit;
  logic [DIGIT_W-1:0] sub_x, sub_y, sub_d;
  logic               sub_bout;

  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_chk
      assign digit_bad[gi] = digit_invalid(a[gi*DIGIT_W +: DIGIT_W]) |
                             digit_invalid(b[gi*DIGIT_W +: DIGIT_W]);
    end
  endgenerate

  assign in_bad     = |digit_bad;
  assign last_digit = (idx_q == LAST_IDX);

  // NEG reuses the digit unit as 0 - diff_i - borrow.
  always_comb begin
    sub_x = '0;
    sub_y = '0;
    if (state_q == NEG) begin
      sub_x = '0;
      sub_y = diff_q[idx_q*DIGIT_W +: DIGIT_W];
    end else begin
      sub_x = a_q[idx_q*DIGIT_W +: DIGIT_W];
      sub_y = b_q[idx_q*DIGIT_W +: DIGIT_W];
    end
  end

  bcd_digit_sub u_digit (
    .x    (sub_x),
    .y    (sub_y),
    .bin  (borrow_q),
    .d    (sub_d),
    .bout (sub_bout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
      borrow_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
      borrow_q <= borrow_d;
      idx_q    <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = in_bad ? DONE : SUB;
      SUB:  if (last_digit) state_d = sub_bout ? NEG : DONE;
      NEG:  if (last_digit) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    neg_d    = neg_q;
    err_d    = err_q;
    borrow_d = borrow_q;
    idx_d    = idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          diff_d   = '0;
          neg_d    = 1'b0;
          err_d    = in_bad;
          borrow_d = 1'b0;
          idx_d    = '0;
        end
      end
      SUB: begin
        diff_d[idx_q*DIGIT_W +: DIGIT_W] = sub_d;
        borrow_d = sub_bout;
        idx_d    = idx_q + 1'b1;
        if (last_digit) begin
          idx_d    = '0;
          borrow_d = 1'b0;
          neg_d    = sub_bout;
        end
      end
      NEG: begin
        diff_d[idx_q*DIGIT_W +: DIGIT_W] = sub_d;
        borrow_d = sub_bout;
        idx_d    = idx_q + 1'b1;
        if (last_digit) begin
          idx_d    = '0;
          borrow_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
    diff = diff_q;
    neg  = neg_q;
    err  = err_q;
  end

endmodule

// File: tb/tb_bcd_serial_sub.sv
// Directed and random checks of bcd_serial_sub (NDIG=4) against an integer
// reference model, with expectations queued at start and checked at done.
module tb_bcd_serial_sub;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;
  logic        busy, done, neg, err;
  logic [15:0] diff;

  typedef struct {
    string       tag;
    logic [15:0] diff;
    logic        neg;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  bcd_serial_sub #(.NDIG(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .neg   (neg),
    .err   (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int n);
    logic [15:0] r = '0;
    int m = n;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic has_bad(input logic [15:0] v);
    logic bad = 1'b0;
    for (int i = 0; i < 4; i++) if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  // start is additionally held high in cycles hold_lo..hold_hi (cycle 0 = accept)
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input int hold_lo, input int hold_hi);
    exp_t e;
    exp_t got;
    int   cyc = 0;
    int   extra_done = 0;
    logic seen = 1'b0;
    logic busy_bad = 1'b0;
    logic [15:0] d_at_done;
    logic n_at_done, e_at_done;
    e.tag = tag;
    if (has_bad(av) || has_bad(bv)) begin
      e.diff = 16'h0; e.neg = 1'b0; e.err = 1'b1; e.lat = 1;
    end else begin
      int x = bcd2int(av);
      int y = bcd2int(bv);
      e.neg  = (x < y);
      e.diff = int2bcd(e.neg ? (y - x) : (x - y));
      e.err  = 1'b0;
      e.lat  = e.neg ? 9 : 5;
    end
    sb.push_back(e);

    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = (cyc >= hold_lo && cyc <= hold_hi);
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (done === 1'b1) seen = 1'b1;
    end
    d_at_done = diff; n_at_done = neg; e_at_done = err;

    got = sb.pop_front();
    check({got.tag, ".latency"}, cyc, got.lat);
    check({got.tag, ".busy"}, busy_bad, 1'b0);
    check({got.tag, ".diff"}, d_at_done, got.diff);
    check({got.tag, ".neg"}, n_at_done, got.neg);
    check({got.tag, ".err"}, e_at_done, got.err);

    @(negedge clk);
    start = 1'b0;
    check({got.tag, ".idle_after"}, {busy, done}, 2'b00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra_done++;
    end
    check({got.tag, ".no_redone"}, extra_done, 0);
    check({got.tag, ".hold"}, {err, neg, diff}, {got.err, got.neg, got.diff});
    $display("op %s a=%h b=%h -> diff=%h neg=%b err=%b latency=%0d",
             got.tag, av, bv, d_at_done, n_at_done, e_at_done, cyc);
  endtask

  initial begin
    int dones;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset.outputs", {busy, done, err, neg, diff}, 20'h0);
    rst = 1'b0;
    @(negedge clk);
    check("reset.idle", {busy, done}, 2'b00);

    run_op("pos",     16'h5432, 16'h1234, 0, 0);
    run_op("neg",     16'h1234, 16'h5432, 0, 0);
    run_op("ripple",  16'h1000, 16'h0001, 0, 0);
    run_op("bad",     16'h12A4, 16'h0001, 0, 0);
    run_op("equal",   16'h9999, 16'h9999, 2, 4);
    run_op("done_st", 16'h0500, 16'h0499, 5, 5);
    run_op("zero",    16'h0000, 16'h9999, 0, 0);

    // abort: reset applied during cycle 3 of a negative operation
    @(negedge clk);
    a = 16'h1234; b = 16'h5432; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("abort.cleared", {busy, done, err, neg, diff}, 20'h0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("abort.no_done", dones, 0);
    run_op("after_abort", 16'h1234, 16'h5432, 0, 0);

    for (int n = 0; n < 6; n++) begin
      logic [15:0] ra, rb;
      for (int i = 0; i < 4; i++) begin
        ra[i*4 +: 4] = 4'($urandom_range(0, 9));
        rb[i*4 +: 4] = 4'($urandom_range(0, 9));
      end
      run_op($sformatf("rand%0d", n), ra, rb, 0, 0);
    end

    check("scoreboard.empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
